prince_round_ctrl: RTL and testbench

//  Parametrised round/stage sequencer for masked round-based PRINCE datapaths with

---
 rtl/prince_ctrl_pkg.sv | 33 +++
 rtl/prince_stage_cnt.sv | 30 +++
 rtl/prince_round_ctrl.sv | 131 +++++++++++++
 tb/tb_prince_round_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prince_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prince_ctrl_pkg: state encoding and timing helpers for the PRINCE round  |
// | sequencer, shared by the controller, the datapath and the bench.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package prince_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FWD  = 3'd1;
  localparam logic [2:0] ST_MID  = 3'd2;
  localparam logic [2:0] ST_BWD  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    FWD  = ST_FWD,
    MID  = ST_MID,
    BWD  = ST_BWD,
    DONE = ST_DONE
  } ctrlState_t;

  // Busy cycles per block: forward rounds, two S-box layers in the middle, backward rounds.
  function automatic int blockLatency(input int sboxStages, input int fwdRounds, input int bwdRounds);
    return sboxStages * (fwdRounds + bwdRounds + 2);
  endfunction

  function automatic int lastRound(input int fwdRounds, input int bwdRounds);
    return fwdRounds + bwdRounds + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prince_stage_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prince_stage_cnt: cycle-within-round counter with clear, enable and a    |
// | programmable terminal value; pulses wrap on the terminal cycle.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prince_stage_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] termVal,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = enable && (count == termVal);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/prince_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prince_round_ctrl: round/stage sequencer for a masked round-based PRINCE |
// | datapath with pipelined S-boxes; start/busy/done handshake.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prince_round_ctrl
  import prince_ctrl_pkg::*;
#(
  parameter int SBOX_STAGES = 6,
  parameter int FWD_ROUNDS  = 5,
  parameter int BWD_ROUNDS  = 5,
  parameter int ROUND_W     = 4,
  parameter int STAGE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [ROUND_W-1:0] round,
  output logic [STAGE_W-1:0] stage,
  output logic               round_start_sel,
  output logic               round_half_sel,
  output logic               round_end_sel,
  output logic               rnd_en,
  output logic               done
);

  localparam logic [ROUND_W-1:0] C_FWD_LAST   = ROUND_W'(FWD_ROUNDS);
  localparam logic [ROUND_W-1:0] C_LAST_ROUND = ROUND_W'(lastRound(FWD_ROUNDS, BWD_ROUNDS));
  localparam logic [STAGE_W-1:0] C_SBOX_TERM  = STAGE_W'(SBOX_STAGES - 1);
  localparam logic [STAGE_W-1:0] C_MID_TERM   = STAGE_W'(2 * SBOX_STAGES - 1);
  localparam logic [STAGE_W-1:0] C_HALF_START = STAGE_W'(SBOX_STAGES);

  if (SBOX_STAGES < 1 || FWD_ROUNDS < 1 || BWD_ROUNDS < 1) begin : g_badCounts
    $error("prince_round_ctrl: SBOX_STAGES, FWD_ROUNDS and BWD_ROUNDS must be >= 1");
  end
  if (lastRound(FWD_ROUNDS, BWD_ROUNDS) > 2**ROUND_W - 1) begin : g_badRoundW
    $error("prince_round_ctrl: ROUND_W too narrow for FWD_ROUNDS+BWD_ROUNDS+1");
  end
  if (2 * SBOX_STAGES - 1 > 2**STAGE_W - 1) begin : g_badStageW
    $error("prince_round_ctrl: STAGE_W too narrow for 2*SBOX_STAGES-1");
  end

  ctrlState_t         r_state;
  logic [ROUND_W-1:0] r_roundCnt;
  logic               r_busy;
  logic               r_done;
  logic               w_stageWrap;
  logic [STAGE_W-1:0] w_stageTerm;

  // The middle round spans two S-box layers (S then S^-1) in one round slot.
  assign w_stageTerm = (r_state == MID) ? C_MID_TERM : C_SBOX_TERM;

  prince_stage_cnt #(
    .WIDTH (STAGE_W)
  ) u_stageCnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (!r_busy),
    .enable  (r_busy),
    .termVal (w_stageTerm),
    .count   (stage),
    .wrap    (w_stageWrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_roundCnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= FWD;
            r_roundCnt <= ROUND_W'(1);
            r_busy     <= 1'b1;
          end
        end
        FWD: begin
          if (w_stageWrap) begin
            r_roundCnt <= r_roundCnt + ROUND_W'(1);
            if (r_roundCnt == C_FWD_LAST) begin
              r_state <= MID;
            end
          end
        end
        MID: begin
          if (w_stageWrap) begin
            r_roundCnt <= r_roundCnt + ROUND_W'(1);
            r_state    <= BWD;
          end
        end
        BWD: begin
          if (w_stageWrap) begin
            if (r_roundCnt == C_LAST_ROUND) begin
              r_state    <= DONE;
              r_roundCnt <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_roundCnt <= r_roundCnt + ROUND_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_roundCnt <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign rnd_en          = r_busy;
  assign done            = r_done;
  assign round           = r_roundCnt;
  assign round_start_sel = start && (r_state == IDLE);
  assign round_end_sel   = (r_state == BWD);
  assign round_half_sel  = (r_state == BWD) || ((r_state == MID) && (stage >= C_HALF_START));

endmodule
`default_nettype wire

// File: tb/tb_prince_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prince_round_ctrl: three configurations of the sequencer against a    |
// | cycle-count reference model, directed vectors and random stimulus.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prince_round_ctrl;
  import prince_ctrl_pkg::*;

  localparam int NDUT = 3;
  localparam int S_ARR [NDUT] = '{6, 1, 2};
  localparam int F_ARR [NDUT] = '{5, 5, 3};
  localparam int B_ARR [NDUT] = '{5, 5, 2};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NDUT-1:0] start = '0;
  logic [NDUT-1:0] busy, rss, half, endSel, rnd, done;
  logic [3:0]      round [NDUT];
  logic [3:0]      stage [NDUT];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k [NDUT] = '{0, 0, 0};
  bit armed = 0;
  int dirOff = -1;

  always #5 clk = ~clk;

  prince_round_ctrl #(.SBOX_STAGES(6), .FWD_ROUNDS(5), .BWD_ROUNDS(5), .ROUND_W(4), .STAGE_W(4)) u_dutA (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .round(round[0]), .stage(stage[0]),
    .round_start_sel(rss[0]), .round_half_sel(half[0]), .round_end_sel(endSel[0]), .rnd_en(rnd[0]), .done(done[0]));
  prince_round_ctrl #(.SBOX_STAGES(1), .FWD_ROUNDS(5), .BWD_ROUNDS(5), .ROUND_W(4), .STAGE_W(4)) u_dutB (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .round(round[1]), .stage(stage[1]),
    .round_start_sel(rss[1]), .round_half_sel(half[1]), .round_end_sel(endSel[1]), .rnd_en(rnd[1]), .done(done[1]));
  prince_round_ctrl #(.SBOX_STAGES(2), .FWD_ROUNDS(3), .BWD_ROUNDS(2), .ROUND_W(4), .STAGE_W(4)) u_dutC (
    .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .round(round[2]), .stage(stage[2]),
    .round_start_sel(rss[2]), .round_half_sel(half[2]), .round_end_sel(endSel[2]), .rnd_en(rnd[2]), .done(done[2]));

  typedef struct {
    int busy; int round; int stage; int half; int endSel; int done;
  } exp_t;

  typedef struct {
    int dut; int off; int busy; int round; int stage; int half; int endSel; int done;
  } vec_t;

  vec_t tbl [$];

  // k counts cycles since the accepted start: 1..N busy, N+1 done, 0 idle.
  function automatic exp_t model(input int s, input int f, input int b, input int kk);
    exp_t e;
    int n;
    int j;
    n = blockLatency(s, f, b);
    e.busy = 0; e.round = 0; e.stage = 0; e.half = 0; e.endSel = 0; e.done = 0;
    if (kk >= 1 && kk <= n) begin
      e.busy = 1;
      j = kk - 1;
      if (j < s * f) begin
        e.round = j / s + 1;
        e.stage = j % s;
      end else if (j < s * (f + 2)) begin
        e.round = f + 1;
        e.stage = j - s * f;
        e.half  = (e.stage >= s) ? 1 : 0;
      end else begin
        j = j - s * (f + 2);
        e.round  = f + 2 + j / s;
        e.stage  = j % s;
        e.half   = 1;
        e.endSel = 1;
      end
    end else if (kk == n + 1) begin
      e.done = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic modelCheck();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      e = model(S_ARR[d], F_ARR[d], B_ARR[d], k[d]);
      chk("busy", d, int'(busy[d]), e.busy);
      chk("round", d, int'(round[d]), e.round);
      chk("stage", d, int'(stage[d]), e.stage);
      chk("half_sel", d, int'(half[d]), e.half);
      chk("end_sel", d, int'(endSel[d]), e.endSel);
      chk("rnd_en", d, int'(rnd[d]), e.busy);
      chk("done", d, int'(done[d]), e.done);
      chk("start_sel", d, int'(rss[d]), (start[d] && k[d] == 0) ? 1 : 0);
    end
  endtask

  task automatic tableCheck();
    foreach (tbl[i]) begin
      if (tbl[i].off == dirOff) begin
        chk("vec_busy", tbl[i].dut, int'(busy[tbl[i].dut]), tbl[i].busy);
        chk("vec_round", tbl[i].dut, int'(round[tbl[i].dut]), tbl[i].round);
        chk("vec_stage", tbl[i].dut, int'(stage[tbl[i].dut]), tbl[i].stage);
        chk("vec_half", tbl[i].dut, int'(half[tbl[i].dut]), tbl[i].half);
        chk("vec_end", tbl[i].dut, int'(endSel[tbl[i].dut]), tbl[i].endSel);
        chk("vec_done", tbl[i].dut, int'(done[tbl[i].dut]), tbl[i].done);
      end
    end
  endtask

  task automatic sample(input logic [NDUT-1:0] st, input logic rst);
    start = st;
    reset = rst;
    @(negedge clk);
    if (armed) begin
      modelCheck();
      if (dirOff >= 0) tableCheck();
    end
  endtask

  task automatic tick();
    int n;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n = blockLatency(S_ARR[d], F_ARR[d], B_ARR[d]);
      if (reset) k[d] = 0;
      else if (k[d] == 0) k[d] = start[d] ? 1 : 0;
      else if (k[d] <= n) k[d] = k[d] + 1;
      else k[d] = 0;
    end
    if (reset) armed = 1;
    cyc++;
    #1;
  endtask

  initial begin
    int doneCnt;
    int busyCnt;

    // dut, offset from start, busy, round, stage, half, end, done
    tbl.push_back('{0,  1, 1,  1,  0, 0, 0, 0});
    tbl.push_back('{0,  6, 1,  1,  5, 0, 0, 0});
    tbl.push_back('{0,  7, 1,  2,  0, 0, 0, 0});
    tbl.push_back('{0, 30, 1,  5,  5, 0, 0, 0});
    tbl.push_back('{0, 31, 1,  6,  0, 0, 0, 0});
    tbl.push_back('{0, 36, 1,  6,  5, 0, 0, 0});
    tbl.push_back('{0, 37, 1,  6,  6, 1, 0, 0});
    tbl.push_back('{0, 42, 1,  6, 11, 1, 0, 0});
    tbl.push_back('{0, 43, 1,  7,  0, 1, 1, 0});
    tbl.push_back('{0, 72, 1, 11,  5, 1, 1, 0});
    tbl.push_back('{0, 73, 0,  0,  0, 0, 0, 1});
    tbl.push_back('{0, 74, 0,  0,  0, 0, 0, 0});
    tbl.push_back('{1,  6, 1,  6,  0, 0, 0, 0});
    tbl.push_back('{1,  7, 1,  6,  1, 1, 0, 0});
    tbl.push_back('{1,  8, 1,  7,  0, 1, 1, 0});
    tbl.push_back('{1, 12, 1, 11,  0, 1, 1, 0});
    tbl.push_back('{1, 13, 0,  0,  0, 0, 0, 1});
    tbl.push_back('{2,  1, 1,  1,  0, 0, 0, 0});
    tbl.push_back('{2,  7, 1,  4,  0, 0, 0, 0});
    tbl.push_back('{2,  9, 1,  4,  2, 1, 0, 0});
    tbl.push_back('{2, 14, 1,  6,  1, 1, 1, 0});
    tbl.push_back('{2, 15, 0,  0,  0, 0, 0, 1});

    for (int i = 0; i < 3; i++) begin sample('0, 1'b1); tick(); end
    for (int i = 0; i < 5; i++) begin
      sample('0, 1'b0);
      if (i == 4) begin
        chk("idle_busy", 0, int'(busy[0]), 0);
        chk("idle_round", 0, int'(round[0]), 0);
        chk("idle_done", 0, int'(done[0]), 0);
      end
      tick();
    end

    // Directed single block on all three configurations.
    for (int off = 0; off <= 76; off++) begin
      dirOff = off;
      sample((off == 0) ? 3'b111 : 3'b000, 1'b0);
      tick();
    end
    dirOff = -1;

    // Start held high continuously on the default configuration.
    for (int off = 0; off <= 76; off++) begin
      sample(3'b001, 1'b0);
      chk("held_start_sel", 0, int'(rss[0]), (off == 0 || off == 74) ? 1 : 0);
      chk("held_done", 0, int'(done[0]), (off == 73) ? 1 : 0);
      tick();
    end
    for (int i = 0; i < 80; i++) begin sample('0, 1'b0); tick(); end

    // Reset during the middle round aborts without done.
    for (int off = 0; off <= 41; off++) begin
      sample((off == 0) ? 3'b001 : 3'b000, off == 40);
      if (off == 41) begin
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_round", 0, int'(round[0]), 0);
        chk("abort_stage", 0, int'(stage[0]), 0);
        chk("abort_half", 0, int'(half[0]), 0);
      end
      tick();
    end
    doneCnt = 0;
    for (int i = 0; i < 80; i++) begin
      sample('0, 1'b0);
      doneCnt += int'(done[0]);
      tick();
    end
    chk("abort_no_done", 0, doneCnt, 0);
    busyCnt = 0;
    doneCnt = 0;
    for (int off = 0; off < 80; off++) begin
      sample((off == 0) ? 3'b001 : 3'b000, 1'b0);
      busyCnt += int'(busy[0]);
      doneCnt += int'(done[0]);
      tick();
    end
    chk("restart_busy_cycles", 0, busyCnt, 72);
    chk("restart_done_count", 0, doneCnt, 1);

    // Random starts with occasional resets.
    for (int i = 0; i < 600; i++) begin
      sample(NDUT'($urandom_range(0, 7) & $urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
